// File: rtl/aes_pkg.sv
// Shared AES constants and lookups: round count, key-schedule rcon, FSM states, forward S-box.
// Pure combinational helpers with no latency and no handshake.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_DONE
  } aes_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Only indices 1..10 are meaningful; anything else yields zero.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_key_expand_seq_if.sv
// Key-schedule bus: key load request, status, and the indexed round-key read port.
// No flow control; loads during expansion are dropped, reads are always accepted.
interface aes_key_expand_seq_if;
  logic [127:0] key_in;
  logic         key_load;
  logic         busy;
  logic         ready;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
  logic         rd_valid;

  modport master (
    output key_in, key_load, rd_idx,
    input  busy, ready, rd_key, rd_valid
  );

  modport slave (
    input  key_in, key_load, rd_idx,
    output busy, ready, rd_key, rd_valid
  );
endinterface

// File: rtl/aes_key_expand_seq_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word.
// Purely combinational, zero latency, no backpressure.
module sub_word
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  assign o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]),
                   sbox(i_word[15:8]),  sbox(i_word[7:0])};

endmodule

// File: rtl/aes_key_expand_seq.sv
// AES-128 key schedule, one round key per clock into an 11-entry buffer; ready 10 cycles after load.
// Registered read port with 1-cycle latency; key_load is dropped while expanding, no queueing.
module aes_key_expand_seq #(
  parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
  input logic                clk,
  input logic                rst_n,
  aes_key_expand_seq_if.slave bus
);

  localparam int         NKEYS = NUM_ROUNDS + 1;
  localparam logic [3:0] LAST  = 4'(NUM_ROUNDS);

  aes_pkg::aes_state_e r_state;
  logic [3:0]          r_cnt;
  logic                r_busy;
  logic                r_ready;
  logic                r_rd_valid;
  logic [127:0]        r_rd_key;
  logic [127:0]        r_last;
  logic [127:0]        r_rk [NKEYS];

  logic         w_load;
  logic         w_ready_next;
  logic         w_idx_ok;
  logic [31:0]  w_rot;
  logic [31:0]  w_sub;
  logic [31:0]  w_t;
  logic [31:0]  w_w0;
  logic [31:0]  w_w1;
  logic [31:0]  w_w2;
  logic [31:0]  w_w3;
  logic [127:0] w_next;

  assign w_load       = bus.key_load && (r_state != aes_pkg::ST_EXPAND);
  // A load in DONE pulls ready low on the same edge, so reads issued then are flagged invalid.
  assign w_ready_next = ((r_state == aes_pkg::ST_EXPAND) && (r_cnt == LAST)) ||
                        ((r_state == aes_pkg::ST_DONE) && !bus.key_load);
  assign w_idx_ok     = (bus.rd_idx <= LAST);

  // r_last mirrors rk[cnt-1], avoiding a wide read mux on the schedule path.
  assign w_rot = {r_last[23:0], r_last[31:24]};

  sub_word u_sub_word (
    .i_word (w_rot),
    .o_word (w_sub)
  );

  assign w_t    = w_sub ^ {aes_pkg::rcon(r_cnt), 24'h0};
  assign w_w0   = r_last[127:96] ^ w_t;
  assign w_w1   = r_last[95:64]  ^ w_w0;
  assign w_w2   = r_last[63:32]  ^ w_w1;
  assign w_w3   = r_last[31:0]   ^ w_w2;
  assign w_next = {w_w0, w_w1, w_w2, w_w3};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= aes_pkg::ST_IDLE;
      r_cnt      <= 4'd0;
      r_busy     <= 1'b0;
      r_ready    <= 1'b0;
      r_rd_key   <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_key   <= w_idx_ok ? r_rk[bus.rd_idx] : '0;
      r_rd_valid <= w_ready_next && w_idx_ok;
      case (r_state)
        aes_pkg::ST_IDLE, aes_pkg::ST_DONE: begin
          if (bus.key_load) begin
            r_state <= aes_pkg::ST_EXPAND;
            r_cnt   <= 4'd1;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
          end
        end
        aes_pkg::ST_EXPAND: begin
          if (r_cnt == LAST) begin
            r_state <= aes_pkg::ST_DONE;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: begin
          r_state <= aes_pkg::ST_IDLE;
          r_cnt   <= 4'd0;
          r_busy  <= 1'b0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Key storage is deliberately unreset; ready/rd_valid qualify its contents.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_rk[0] <= bus.key_in;
      r_last  <= bus.key_in;
    end else if (r_state == aes_pkg::ST_EXPAND) begin
      r_rk[r_cnt] <= w_next;
      r_last      <= w_next;
    end
  end

  assign bus.busy     = r_busy;
  assign bus.ready    = r_ready;
  assign bus.rd_key   = r_rd_key;
  assign bus.rd_valid = r_rd_valid;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Bench for aes_key_expand_seq: FIPS-197 key-expansion model built from GF(2^8) arithmetic,
// per-cycle output comparison, plus directed vectors with literal round keys.
module tb_aes_key_expand_seq;

  localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK_A1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK_A10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_B  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RK_B10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes_key_expand_seq_if bus();

  aes_key_expand_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: S-box from field inverse + affine map ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    if (x == 8'h00) return 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(x, 8'(y)) == 8'h01) return 8'(y);
    return 8'h00;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox_m(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  // Textbook word-oriented expansion of all 44 words, returning round r.
  function automatic logic [127:0] model_rk(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m(t[31:24]), sbox_m(t[23:16]), sbox_m(t[15:8]), sbox_m(t[7:0])};
        t[31:24] = t[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // ---------------- cycle-level expectation ----------------
  // m_age: edges since the accepted load (saturating at 10), -1 when no schedule is running.
  int           m_age   = -1;
  logic [127:0] m_sched [11];
  logic [127:0] m_buf   [11];
  bit           m_known [11];
  logic [127:0] e_key   = '0;
  bit           e_known = 1'b1;
  bit           e_valid = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age   = -1;
      e_key   = '0;
      e_known = 1'b1;
      e_valid = 1'b0;
    end else begin
      int idx;
      idx = int'(bus.rd_idx);
      if (idx <= 10) begin
        e_key   = m_buf[idx];
        e_known = m_known[idx];
      end else begin
        e_key   = '0;
        e_known = 1'b1;
      end
      if (bus.key_load && (m_age < 0 || m_age == 10)) begin
        m_age      = 0;
        m_buf[0]   = bus.key_in;
        m_known[0] = 1'b1;
        for (int r = 0; r < 11; r++) m_sched[r] = model_rk(bus.key_in, r);
      end else if (m_age >= 0 && m_age < 10) begin
        m_age          = m_age + 1;
        m_buf[m_age]   = m_sched[m_age];
        m_known[m_age] = 1'b1;
      end
      e_valid = (m_age == 10) && (idx <= 10);
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy",     128'(bus.busy),     128'(m_age >= 0 && m_age < 10));
      chk("ready",    128'(bus.ready),    128'(m_age == 10));
      chk("rd_valid", 128'(bus.rd_valid), 128'(e_valid));
      if (e_known) chk("rd_key", bus.rd_key, e_key);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read(input logic [3:0] idx);
    bus.rd_idx = idx;
    step();
  endtask

  // Loads k, then counts edges after the load edge until ready; ghost pulses key_load at E3/E7.
  task automatic load_wait(input logic [127:0] k, input bit ghost, output int lat);
    bus.key_in   = k;
    bus.key_load = 1'b1;
    step();
    bus.key_load = 1'b0;
    chk("ready_drop_after_load", 128'(bus.ready), 128'd0);
    chk("busy_after_load", 128'(bus.busy), 128'd1);
    chk("rd_valid_on_load_edge", 128'(bus.rd_valid), 128'd0);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      if (ghost) begin
        bus.key_load = (c == 3 || c == 7);
        bus.key_in   = ~k;
      end
      step();
      if (bus.ready && lat < 0) begin
        lat = c;
        break;
      end
    end
    bus.key_load = 1'b0;
    bus.key_in   = k;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    rst_n        = 1'b1;
    bus.key_in   = '0;
    bus.key_load = 1'b0;
    bus.rd_idx   = 4'd0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    chk("reset_busy",     128'(bus.busy),     128'd0);
    chk("reset_ready",    128'(bus.ready),    128'd0);
    chk("reset_rd_valid", 128'(bus.rd_valid), 128'd0);
    chk("reset_rd_key",   bus.rd_key,         128'd0);
    rst_n = 1'b1;
    step();
    step();

    chk("model_A_rk1",  model_rk(KEY_A, 1),  RK_A1);
    chk("model_A_rk10", model_rk(KEY_A, 10), RK_A10);
    chk("model_B_rk10", model_rk(KEY_B, 10), RK_B10);

    // FIPS-197 A.1
    load_wait(KEY_A, 1'b0, lat);
    chk("A_ready_latency", 128'(lat), 128'd10);
    read(4'd1);
    chk("A_rk1", bus.rd_key, RK_A1);
    chk("A_rk1_valid", 128'(bus.rd_valid), 128'd1);
    read(4'd10);
    chk("A_rk10", bus.rd_key, RK_A10);
    read(4'd0);
    chk("A_rk0", bus.rd_key, KEY_A);

    // Reverse walk, one index per cycle
    for (int i = 10; i >= 0; i--) begin
      read(4'(i));
      chk("walk_valid", 128'(bus.rd_valid), 128'd1);
    end
    chk("walk_last_rk0", bus.rd_key, KEY_A);

    // Loads during expansion are ignored
    load_wait(KEY_A, 1'b1, lat);
    chk("ghost_ready_latency", 128'(lat), 128'd10);
    read(4'd10);
    chk("ghost_rk10", bus.rd_key, RK_A10);
    read(4'd1);
    chk("ghost_rk1", bus.rd_key, RK_A1);

    // Restart in DONE with a concurrent read of index 5
    bus.rd_idx = 4'd5;
    load_wait(KEY_B, 1'b0, lat);
    chk("B_ready_latency", 128'(lat), 128'd10);
    read(4'd10);
    chk("B_rk10", bus.rd_key, RK_B10);
    read(4'd0);
    chk("B_rk0", bus.rd_key, KEY_B);

    // Illegal indices
    read(4'd11);
    chk("idx11_key",   bus.rd_key, 128'd0);
    chk("idx11_valid", 128'(bus.rd_valid), 128'd0);
    read(4'd15);
    chk("idx15_key",   bus.rd_key, 128'd0);
    chk("idx15_valid", 128'(bus.rd_valid), 128'd0);
    read(4'd10);
    chk("idx10_after_bad_key",   bus.rd_key, RK_B10);
    chk("idx10_after_bad_valid", 128'(bus.rd_valid), 128'd1);

    // Reset in the middle of expansion
    bus.key_in   = KEY_A;
    bus.key_load = 1'b1;
    step();
    bus.key_load = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",     128'(bus.busy),     128'd0);
    chk("midrst_ready",    128'(bus.ready),    128'd0);
    chk("midrst_rd_valid", 128'(bus.rd_valid), 128'd0);
    chk("midrst_rd_key",   bus.rd_key,         128'd0);
    step();
    rst_n = 1'b1;
    repeat (6) step();
    chk("post_rst_idle_busy",  128'(bus.busy),  128'd0);
    chk("post_rst_idle_ready", 128'(bus.ready), 128'd0);

    load_wait(KEY_B, 1'b0, lat);
    chk("post_rst_ready_latency", 128'(lat), 128'd10);
    read(4'd10);
    chk("post_rst_rk10", bus.rd_key, RK_B10);
    step();

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
